// File: rtl/tetris_pkg.sv
// Shared types and width helpers for the executor scheduler.
package tetris_pkg;

  typedef enum logic [1:0] {
    eIDLE  = 2'd0,
    eStart = 2'd1,
    eRun   = 2'd2
  } sched_state_e;

  // Index width for n items; never less than one bit so ports stay legal.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request above last_i, wrapping.
module rr_arbiter
  import tetris_pkg::*;
#(
  parameter int num_req_p = 4,
  localparam int id_w = clog2_min1(num_req_p)
) (
  input  logic [num_req_p-1:0] req_i,
  input  logic [id_w-1:0]      last_i,
  output logic [id_w-1:0]      sel_o,
  output logic                 valid_o
);

  int idx;

  // Scan from the farthest offset down so the nearest candidate wins.
  always_comb begin
    sel_o   = '0;
    valid_o = 1'b0;
    idx     = 0;
    for (int i = num_req_p; i >= 1; i--) begin
      idx = (int'(last_i) + i) % num_req_p;
      if (req_i[idx]) begin
        sel_o   = id_w'(idx);
        valid_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/executor_scheduler.sv
// Grants shared matrix-memory access to one executor at a time (round-robin),
// with a hard-wired lock->check chain and a watchdog for hung executors.
module executor_scheduler
  import tetris_pkg::*;
#(
  parameter int width_p     = 16,
  parameter int height_p    = 32,
  parameter int num_req_p   = 4,
  parameter int chain_src_p = 0,
  parameter int chain_dst_p = 1,
  parameter int timeout_p   = 1024,
  localparam int addr_w = clog2_min1(height_p),
  localparam int id_w   = clog2_min1(num_req_p)
) (
  input  logic                           clk_i,
  input  logic                           reset_i,
  input  logic [num_req_p-1:0]           req_i,
  output logic [num_req_p-1:0]           exec_v_o,
  input  logic [num_req_p-1:0]           exec_done_i,
  output logic                           busy_o,
  output logic [id_w-1:0]                grant_id_o,
  output logic                           error_o,
  input  logic [num_req_p*addr_w-1:0]    exec_read_addr_i,
  input  logic [num_req_p*addr_w-1:0]    exec_write_addr_i,
  input  logic [num_req_p*width_p-1:0]   exec_write_data_i,
  input  logic [num_req_p-1:0]           exec_write_v_i,
  input  logic [addr_w-1:0]              disp_read_addr_i,
  output logic [addr_w-1:0]              mm_read_addr_o,
  output logic [addr_w-1:0]              mm_write_addr_o,
  output logic [width_p-1:0]             mm_write_data_o,
  output logic                           mm_write_v_o
);

  localparam int wd_w = clog2_min1(timeout_p + 1);
  localparam logic [wd_w-1:0] wd_last = wd_w'((timeout_p == 0) ? 0 : timeout_p - 1);
  localparam logic [id_w-1:0] chain_src = id_w'(chain_src_p);
  localparam logic [id_w-1:0] chain_dst = id_w'(chain_dst_p);

  sched_state_e           state_q, state_d;
  logic [num_req_p-1:0]   pending_q, pending_d;
  logic [id_w-1:0]        grant_q, grant_d;
  logic [id_w-1:0]        last_q, last_d;
  logic [wd_w-1:0]        wd_cnt_q, wd_cnt_d;
  logic                   error_q, error_d;
  logic [num_req_p-1:0]   clear;
  logic [id_w-1:0]        arb_sel;
  logic                   arb_valid;

  rr_arbiter #(.num_req_p(num_req_p)) u_arb (
    .req_i   (pending_q),
    .last_i  (last_q),
    .sel_o   (arb_sel),
    .valid_o (arb_valid)
  );

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q   <= eIDLE;
      pending_q <= '0;
      grant_q   <= '0;
      last_q    <= id_w'(num_req_p - 1);
      wd_cnt_q  <= '0;
      error_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      grant_q   <= grant_d;
      last_q    <= last_d;
      wd_cnt_q  <= wd_cnt_d;
      error_q   <= error_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    last_d   = last_q;
    wd_cnt_d = wd_cnt_q;
    error_d  = error_q;
    clear    = '0;
    exec_v_o = '0;
    case (state_q)
      eIDLE: begin
        if (arb_valid) begin
          grant_d        = arb_sel;
          last_d         = arb_sel;
          clear[arb_sel] = 1'b1;
          state_d        = eStart;
        end
      end
      eStart: begin
        exec_v_o[grant_q] = 1'b1;
        wd_cnt_d          = '0;
        state_d           = eRun;
      end
      eRun: begin
        // Done takes priority over a watchdog expiry in the same cycle.
        if (exec_done_i[grant_q]) begin
          if (grant_q == chain_src) begin
            grant_d          = chain_dst;
            last_d           = chain_dst;
            clear[chain_dst] = 1'b1;
            state_d          = eStart;
          end else begin
            state_d = eIDLE;
          end
        end else if (timeout_p != 0) begin
          if (wd_cnt_q == wd_last) begin
            error_d = 1'b1;
            state_d = eIDLE;
          end else begin
            wd_cnt_d = wd_cnt_q + wd_w'(1);
          end
        end
      end
      default: state_d = eIDLE;
    endcase
    pending_d = (pending_q | req_i) & ~clear;
  end

  // Executors present their reset read address during start, so route it then too.
  always_comb begin
    if (state_q == eIDLE) mm_read_addr_o = disp_read_addr_i;
    else                  mm_read_addr_o = exec_read_addr_i[grant_q*addr_w +: addr_w];
  end

  assign mm_write_addr_o = exec_write_addr_i[grant_q*addr_w +: addr_w];
  assign mm_write_data_o = exec_write_data_i[grant_q*width_p +: width_p];
  assign mm_write_v_o    = (state_q == eRun) && exec_write_v_i[grant_q];
  assign busy_o          = (state_q != eIDLE);
  assign grant_id_o      = grant_q;
  assign error_o         = error_q;

endmodule
